wb_result_arbiter: RTL and testbench
====================================

Name: wb_result_arbiter

Overview:
- Producer side of the writeback interface consumed by the forwarding unit and register file.
- Merges ALU results and load results onto a single registered write port (uses_rw / rw_addr / rw_data).
- Load results have absolute priority because the memory stage cannot stall.
- ALU results that lose arbitration are held in a small FIFO, with valid/ready backpressure to EX.

Parameters:
- DATA_WIDTH, 32, width of result data.
- PHYS_ADDR_WIDTH, 6, physical register address width (64 physical registers).
- FIFO_DEPTH, 4, ALU holding FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  pipeline flush; discards all buffered and incoming results
- i_alu_valid  in  1  ALU result offered
- o_alu_ready  out  1  ALU result accepted when valid&ready
- i_alu_addr  in  PHYS_ADDR_WIDTH  ALU destination physical register
- i_alu_data  in  DATA_WIDTH  ALU result
- i_mem_valid  in  1  load result present; no backpressure
- i_mem_addr  in  PHYS_ADDR_WIDTH  load destination physical register
- i_mem_data  in  DATA_WIDTH  load data
- o_wb_uses_rw  out  1  write port valid
- o_wb_rw_addr  out  PHYS_ADDR_WIDTH  write port address
- o_wb_rw_data  out  DATA_WIDTH  write port data
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- o_overflow  out  1  sticky error: load collided with a full-FIFO drain failure (never expected)

Behaviour:
- Reset (rst_n low, asynchronous):
  - o_wb_uses_rw=0, o_wb_rw_addr=0, o_wb_rw_data=0.
  - FIFO pointers=0, o_fifo_count=0, o_overflow=0.
  - o_alu_ready=1 once reset deasserts.
- o_alu_ready = (o_fifo_count < FIFO_DEPTH), combinational from registered count only. Accept = i_alu_valid & o_alu_ready.
- Per-cycle selection for the output register, evaluated in priority order:
  1. i_flush: output register loads uses_rw=0; FIFO cleared; the accepted ALU and load inputs of that cycle are dropped.
  2. i_mem_valid: output loads the mem triple. An accepted ALU input is enqueued. FIFO does not dequeue.
  3. FIFO non-empty: output loads the FIFO head (dequeue). An accepted ALU input is enqueued in the same cycle; count is unchanged.
  4. FIFO empty and ALU accepted: ALU triple goes straight to the output register (bypass, no enqueue).
  5. Otherwise: output loads uses_rw=0. Address and data hold their previous values.
- Latency:
  - Load: exactly 1 cycle.
  - ALU: 1 cycle when the FIFO is empty and no load is present; otherwise 1 + queue position + intervening loads.
- Ordering:
  - ALU results leave in acceptance order.
  - Loads may overtake ALU results; this is legal because physical destinations are unique.
- Full FIFO: o_alu_ready=0. A simultaneous dequeue does not raise ready in the same cycle; ready rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is a separate register, updated +1 / -1 / 0 per cycle.
- o_overflow is set if an enqueue is attempted while count==FIFO_DEPTH. This is unreachable by construction and is kept as an assertion hook. It clears only on reset.
- Output register updates every cycle, including holding uses_rw=0. Nothing is combinational from inputs to o_wb_*.

Test Plan:
- Reset mid-operation: FIFO count=3 and uses_rw=1, pull rst_n low asynchronously → same instant uses_rw=0, o_fifo_count=0; after release o_alu_ready=1 and first ALU (addr 5, data 0x11) appears on the next cycle.
- Bypass: idle, ALU valid addr 7 data 0xDEAD_BEEF at cycle N → cycle N+1 uses_rw=1 addr 7 data 0xDEADBEEF; count stays 0.
- Load priority: cycle N load addr 3 data 0xAA and ALU addr 4 data 0xBB → N+1 writes addr 3; N+2 writes addr 4; count 1 then 0.
- Backpressure: loads every cycle for 6 cycles while ALU offers addrs 10..15 → ready drops after 4 accepts (addrs 10..13); after loads stop, writes 10,11,12,13 in order, then 14,15.
- Flush: FIFO holds 2 entries, i_flush with i_mem_valid addr 9 → next cycle uses_rw=0, count=0, addr 9 never written.
- Simultaneous enqueue/dequeue: count=2, no load, ALU accepted → head written, count stays 2, FIFO order preserved.

Source files
------------

// File: rtl/wb_result_arbiter.sv
// Writeback result arbiter: merges load and ALU results onto one registered write port.
// Loads always win; ALU results that lose arbitration wait in a small in-order FIFO.
module wb_result_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int PHYS_ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  input  logic                          i_alu_valid,
  output logic                          o_alu_ready,
  input  logic [PHYS_ADDR_WIDTH-1:0]    i_alu_addr,
  input  logic [DATA_WIDTH-1:0]         i_alu_data,
  input  logic                          i_mem_valid,
  input  logic [PHYS_ADDR_WIDTH-1:0]    i_mem_addr,
  input  logic [DATA_WIDTH-1:0]         i_mem_data,
  output logic                          o_wb_uses_rw,
  output logic [PHYS_ADDR_WIDTH-1:0]    o_wb_rw_addr,
  output logic [DATA_WIDTH-1:0]         o_wb_rw_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [PHYS_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      fifo_data [FIFO_DEPTH];

  logic [PW-1:0]              wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]              rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]              count, count_nxt;
  logic                       uses_nxt;
  logic [PHYS_ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0]      data_nxt;
  logic                       accept, enq, deq, overflow_set;

  // Ready depends only on the registered count, so a dequeue never opens a slot in the same cycle.
  assign o_alu_ready  = (count < DEPTH_C);
  assign accept       = i_alu_valid & o_alu_ready;
  assign o_fifo_count = count;

  always_comb begin
    uses_nxt     = 1'b0;
    addr_nxt     = o_wb_rw_addr;
    data_nxt     = o_wb_rw_data;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    enq          = 1'b0;
    deq          = 1'b0;
    overflow_set = 1'b0;

    if (i_flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else if (i_mem_valid) begin
      uses_nxt = 1'b1;
      addr_nxt = i_mem_addr;
      data_nxt = i_mem_data;
      enq      = accept;
    end else if (count != '0) begin
      uses_nxt = 1'b1;
      addr_nxt = fifo_addr[rd_ptr];
      data_nxt = fifo_data[rd_ptr];
      deq      = 1'b1;
      enq      = accept;
    end else if (accept) begin
      uses_nxt = 1'b1;
      addr_nxt = i_alu_addr;
      data_nxt = i_alu_data;
    end

    if (enq) wr_ptr_nxt = wr_ptr + 1'b1;
    if (deq) rd_ptr_nxt = rd_ptr + 1'b1;

    if (i_flush)
      count_nxt = '0;
    else if (enq && !deq)
      count_nxt = count + 1'b1;
    else if (deq && !enq)
      count_nxt = count - 1'b1;

    overflow_set = enq && (count == DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb_uses_rw <= 1'b0;
      o_wb_rw_addr <= '0;
      o_wb_rw_data <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_overflow   <= 1'b0;
    end else begin
      o_wb_uses_rw <= uses_nxt;
      o_wb_rw_addr <= addr_nxt;
      o_wb_rw_data <= data_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      if (overflow_set) o_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= i_alu_addr;
      fifo_data[wr_ptr] <= i_alu_data;
    end
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed self-checking bench for wb_result_arbiter with hand-computed expectations.
module tb_wb_result_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [5:0]  i_alu_addr;
  logic [31:0] i_alu_data;
  logic        i_mem_valid;
  logic [5:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_wb_uses_rw;
  logic [5:0]  o_wb_rw_addr;
  logic [31:0] o_wb_rw_data;
  logic [2:0]  o_fifo_count;
  logic        o_overflow;

  int errors = 0;
  int checks = 0;

  wb_result_arbiter #(
    .DATA_WIDTH(32),
    .PHYS_ADDR_WIDTH(6),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_flush(i_flush),
    .i_alu_valid(i_alu_valid),
    .o_alu_ready(o_alu_ready),
    .i_alu_addr(i_alu_addr),
    .i_alu_data(i_alu_data),
    .i_mem_valid(i_mem_valid),
    .i_mem_addr(i_mem_addr),
    .i_mem_data(i_mem_data),
    .o_wb_uses_rw(o_wb_uses_rw),
    .o_wb_rw_addr(o_wb_rw_addr),
    .o_wb_rw_data(o_wb_rw_data),
    .o_fifo_count(o_fifo_count),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                              input int count);
    check_output({tag, "_uses"}, {31'd0, o_wb_uses_rw}, 32'd1);
    check_output({tag, "_addr"}, {26'd0, o_wb_rw_addr}, {26'd0, addr});
    check_output({tag, "_data"}, o_wb_rw_data, data);
    check_output({tag, "_count"}, {29'd0, o_fifo_count}, 32'(count));
  endtask

  task automatic apply_stimulus(input logic mv, input logic [5:0] ma, input logic [31:0] md,
                                input logic av, input logic [5:0] aa, input logic [31:0] ad);
    i_mem_valid = mv;
    i_mem_addr  = ma;
    i_mem_data  = md;
    i_alu_valid = av;
    i_alu_addr  = aa;
    i_alu_data  = ad;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_flush = 1'b0;
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);

    // Reset state
    #12;
    check_output("rst_uses", {31'd0, o_wb_uses_rw}, 32'd0);
    check_output("rst_addr", {26'd0, o_wb_rw_addr}, 32'd0);
    check_output("rst_data", o_wb_rw_data, 32'd0);
    check_output("rst_count", {29'd0, o_fifo_count}, 32'd0);
    check_output("rst_ovf", {31'd0, o_overflow}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("rst_ready", {31'd0, o_alu_ready}, 32'd1);
    tick();

    // Bypass path
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd7, 32'hDEAD_BEEF);
    tick();
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    expect_write("byp", 6'd7, 32'hDEAD_BEEF, 0);
    tick();
    check_output("idle_uses", {31'd0, o_wb_uses_rw}, 32'd0);
    check_output("idle_addr_hold", {26'd0, o_wb_rw_addr}, 32'd7);

    // Load priority over ALU
    apply_stimulus(1'b1, 6'd3, 32'hAA, 1'b1, 6'd4, 32'hBB);
    tick();
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    expect_write("prio_load", 6'd3, 32'hAA, 1);
    tick();
    expect_write("prio_alu", 6'd4, 32'hBB, 0);
    tick();
    check_output("prio_idle", {31'd0, o_wb_uses_rw}, 32'd0);

    // Backpressure: loads every cycle, ALU offers 10..15
    begin
      logic [5:0] next_alu;
      next_alu = 6'd10;
      for (int i = 0; i < 6; i++) begin
        apply_stimulus(1'b1, 6'(20 + i), 32'h100 + 32'(i), 1'b1, next_alu, 32'h200 + 32'(next_alu));
        check_output($sformatf("bp_ready%0d", i), {31'd0, o_alu_ready}, (i < 4) ? 32'd1 : 32'd0);
        if (i < 4) next_alu = next_alu + 6'd1;
        tick();
        expect_write($sformatf("bp_load%0d", i), 6'(20 + i), 32'h100 + 32'(i), (i < 4) ? i + 1 : 4);
      end
      apply_stimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd14, 32'h200 + 32'd14);
      check_output("bp_full_ready", {31'd0, o_alu_ready}, 32'd0);
      tick();
      expect_write("bp_w10", 6'd10, 32'h200 + 32'd10, 3);
      check_output("bp_ready_back", {31'd0, o_alu_ready}, 32'd1);
      tick();
      expect_write("bp_w11", 6'd11, 32'h200 + 32'd11, 3);
      apply_stimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd15, 32'h200 + 32'd15);
      tick();
      expect_write("bp_w12", 6'd12, 32'h200 + 32'd12, 3);
      apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
      tick();
      expect_write("bp_w13", 6'd13, 32'h200 + 32'd13, 2);
      tick();
      expect_write("bp_w14", 6'd14, 32'h200 + 32'd14, 1);
      tick();
      expect_write("bp_w15", 6'd15, 32'h200 + 32'd15, 0);
      tick();
      check_output("bp_idle", {31'd0, o_wb_uses_rw}, 32'd0);
    end

    // Flush discards buffered entries and the colliding load
    apply_stimulus(1'b1, 6'd40, 32'h40, 1'b1, 6'd30, 32'h30);
    tick();
    apply_stimulus(1'b1, 6'd41, 32'h41, 1'b1, 6'd31, 32'h31);
    tick();
    check_output("fl_pre_count", {29'd0, o_fifo_count}, 32'd2);
    i_flush = 1'b1;
    apply_stimulus(1'b1, 6'd9, 32'h99, 1'b1, 6'd32, 32'h32);
    tick();
    i_flush = 1'b0;
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    check_output("fl_uses", {31'd0, o_wb_uses_rw}, 32'd0);
    check_output("fl_count", {29'd0, o_fifo_count}, 32'd0);
    check_output("fl_addr_hold", {26'd0, o_wb_rw_addr}, 32'd41);
    tick();
    check_output("fl_post_uses", {31'd0, o_wb_uses_rw}, 32'd0);
    check_output("fl_post_addr", {26'd0, o_wb_rw_addr}, 32'd41);

    // Simultaneous enqueue and dequeue
    apply_stimulus(1'b1, 6'd50, 32'h50, 1'b1, 6'd60, 32'h60);
    tick();
    apply_stimulus(1'b1, 6'd51, 32'h51, 1'b1, 6'd61, 32'h61);
    tick();
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd62, 32'h62);
    tick();
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    expect_write("sim_w60", 6'd60, 32'h60, 2);
    tick();
    expect_write("sim_w61", 6'd61, 32'h61, 1);
    tick();
    expect_write("sim_w62", 6'd62, 32'h62, 0);
    tick();

    // Asynchronous reset in the middle of traffic
    apply_stimulus(1'b1, 6'd70, 32'h70, 1'b1, 6'd80, 32'h80);
    tick();
    apply_stimulus(1'b1, 6'd71, 32'h71, 1'b1, 6'd81, 32'h81);
    tick();
    apply_stimulus(1'b1, 6'd72, 32'h72, 1'b1, 6'd82, 32'h82);
    tick();
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    expect_write("mid_pre", 6'd72, 32'h72, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_uses", {31'd0, o_wb_uses_rw}, 32'd0);
    check_output("mid_rst_count", {29'd0, o_fifo_count}, 32'd0);
    check_output("mid_rst_addr", {26'd0, o_wb_rw_addr}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check_output("mid_ready", {31'd0, o_alu_ready}, 32'd1);
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 32'h11);
    tick();
    apply_stimulus(1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0);
    expect_write("mid_first", 6'd5, 32'h11, 0);
    check_output("ovf_final", {31'd0, o_overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
